wb_grf: RTL and testbench

WB_GRF -- requirements
Module: wb_grf

---
 rtl/wb_grf.sv | 168 ++++++++++++++++
 tb/tb_wb_grf.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_grf.sv
// ---------------------------------------------------------------------------
// wb_grf -- write-back stage general register file
//
// Holds the 31 architectural registers $1..$31 ($0 is hard-wired to zero and
// has no storage). Selects the write-back value from the W-stage payload and
// writes it. The two combinational read ports forward the value being written
// in the same cycle. Also counts retired instructions and keeps a registered
// write-back trace.
//
// Ports
//   clk          in   1   clock, all state changes on posedge
//   reset        in   1   asynchronous, active-low reset
//   RegWrite_W   in   1   write-back enable
//   MemtoReg_W   in   1   load data instead of ALU result (WriteSel_W = 00)
//   WriteSel_W   in   2   00 ALU/load, 01 PC+8, 10 imm<<16, 11 imm
//   ReadData_W   in  32   load data
//   ALUOut_W     in  32   ALU result
//   PC_W         in  32   PC of the retiring instruction
//   SignImm_W    in  32   sign-extended immediate
//   Instr_W      in  32   instruction word (0 = bubble)
//   WriteReg_W   in   5   destination register
//   RA1, RA2     in   5   read addresses
//   RD1, RD2     out 32   combinational read data
//   WD_W         out 32   selected write-back value (for forwarding)
//   retired_cnt  out 32   retired non-bubble instruction count
//   trace_valid  out  1   a register was written on the previous edge
//   trace_pc     out 32   PC of the last write
//   trace_reg    out  5   destination of the last write
//   trace_data   out 32   value of the last write
// ---------------------------------------------------------------------------
module wb_grf #(
    parameter bit TRACE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_W,
    input  logic        MemtoReg_W,
    input  logic [1:0]  WriteSel_W,
    input  logic [31:0] ReadData_W,
    input  logic [31:0] ALUOut_W,
    input  logic [31:0] PC_W,
    input  logic [31:0] SignImm_W,
    input  logic [31:0] Instr_W,
    input  logic [4:0]  WriteReg_W,
    input  logic [4:0]  RA1,
    input  logic [4:0]  RA2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [31:0] WD_W,
    output logic [31:0] retired_cnt,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_reg,
    output logic [31:0] trace_data
);

    // Register storage, $0 deliberately absent
    logic [31:0] regs_q [1:31];
    logic [31:0] cnt_q;
    logic        trace_valid_q;
    logic [31:0] trace_pc_q;
    logic [4:0]  trace_reg_q;
    logic [31:0] trace_data_q;

    logic        we;
    logic [31:0] wd_d;
    logic [31:0] cnt_d;

    // ------------------------------------------------------------------
    // Write-back value selection
    // ------------------------------------------------------------------
    always_comb begin
        wd_d = '0;
        unique case (WriteSel_W)
            2'b00:   wd_d = MemtoReg_W ? ReadData_W : ALUOut_W;
            2'b01:   wd_d = PC_W + 32'd8;              // link address, wraps mod 2^32
            2'b10:   wd_d = {SignImm_W[15:0], 16'h0000}; // lui
            default: wd_d = SignImm_W;
        endcase
    end

    assign WD_W = wd_d;

    // A write to $0 is dropped everywhere: storage, bypass and trace.
    assign we = RegWrite_W && (WriteReg_W != 5'd0);

    // ------------------------------------------------------------------
    // Read ports with same-cycle write-through bypass
    // ------------------------------------------------------------------
    always_comb begin
        RD1 = '0;
        if (RA1 == 5'd0)
            RD1 = '0;
        else if (we && (RA1 == WriteReg_W))
            RD1 = wd_d;
        else
            RD1 = regs_q[RA1];
    end

    always_comb begin
        RD2 = '0;
        if (RA2 == 5'd0)
            RD2 = '0;
        else if (we && (RA2 == WriteReg_W))
            RD2 = wd_d;
        else
            RD2 = regs_q[RA2];
    end

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++)
                regs_q[i] <= '0;
        end else if (we) begin
            regs_q[WriteReg_W] <= wd_d;
        end
    end

    // ------------------------------------------------------------------
    // Retired-instruction counter; bubbles (Instr_W == 0) do not count,
    // whether or not they write a register.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (Instr_W != 32'd0)
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign retired_cnt = cnt_q;

    // ------------------------------------------------------------------
    // Write-back trace: valid pulses per write, payload holds until the
    // next write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_reg_q   <= '0;
            trace_data_q  <= '0;
        end else begin
            trace_valid_q <= we;
            if (we) begin
                trace_pc_q   <= PC_W;
                trace_reg_q  <= WriteReg_W;
                trace_data_q <= wd_d;
            end
        end
    end

    // When tracing is disabled the outputs are tied off and the flops
    // above have no load.
    assign trace_valid = TRACE_EN ? trace_valid_q : 1'b0;
    assign trace_pc    = TRACE_EN ? trace_pc_q    : 32'd0;
    assign trace_reg   = TRACE_EN ? trace_reg_q   : 5'd0;
    assign trace_data  = TRACE_EN ? trace_data_q  : 32'd0;

endmodule

// File: tb/tb_wb_grf.sv
module tb_wb_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_W, MemtoReg_W;
    logic [1:0]  WriteSel_W;
    logic [31:0] ReadData_W, ALUOut_W, PC_W, SignImm_W, Instr_W;
    logic [4:0]  WriteReg_W, RA1, RA2;

    logic [31:0] RD1, RD2, WD_W, retired_cnt, trace_pc, trace_data;
    logic        trace_valid;
    logic [4:0]  trace_reg;

    logic [31:0] RD1_n, RD2_n, WD_W_n, retired_cnt_n, trace_pc_n, trace_data_n;
    logic        trace_valid_n;
    logic [4:0]  trace_reg_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_grf #(.TRACE_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .RegWrite_W(RegWrite_W), .MemtoReg_W(MemtoReg_W), .WriteSel_W(WriteSel_W),
        .ReadData_W(ReadData_W), .ALUOut_W(ALUOut_W), .PC_W(PC_W),
        .SignImm_W(SignImm_W), .Instr_W(Instr_W), .WriteReg_W(WriteReg_W),
        .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2), .WD_W(WD_W),
        .retired_cnt(retired_cnt), .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_reg(trace_reg), .trace_data(trace_data)
    );

    wb_grf #(.TRACE_EN(1'b0)) dut_nt (
        .clk(clk), .reset(reset),
        .RegWrite_W(RegWrite_W), .MemtoReg_W(MemtoReg_W), .WriteSel_W(WriteSel_W),
        .ReadData_W(ReadData_W), .ALUOut_W(ALUOut_W), .PC_W(PC_W),
        .SignImm_W(SignImm_W), .Instr_W(Instr_W), .WriteReg_W(WriteReg_W),
        .RA1(RA1), .RA2(RA2), .RD1(RD1_n), .RD2(RD2_n), .WD_W(WD_W_n),
        .retired_cnt(retired_cnt_n), .trace_valid(trace_valid_n), .trace_pc(trace_pc_n),
        .trace_reg(trace_reg_n), .trace_data(trace_data_n)
    );

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [1:0]  ws;
        logic [31:0] rdata, alu, pc, simm, instr;
        logic [4:0]  wreg, ra1, ra2;
        logic [31:0] e_wd, e_rd1, e_rd2;
        logic        e_tv;
        logic [4:0]  e_treg;
        logic [31:0] e_tdata, e_tpc, e_cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic [1:0] ws,
                         input logic [31:0] rdata, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [31:0] simm,
                         input logic [31:0] instr, input logic [4:0] wreg,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        RegWrite_W = rw;  MemtoReg_W = m2r; WriteSel_W = ws;
        ReadData_W = rdata; ALUOut_W = alu; PC_W = pc; SignImm_W = simm;
        Instr_W = instr; WriteReg_W = wreg; RA1 = ra1; RA2 = ra2;
    endtask

    task automatic chk_nt_trace(input string tag);
        chk({tag, " nt.trace_valid"}, {31'd0, trace_valid_n}, 32'd0);
        chk({tag, " nt.trace_reg"},   {27'd0, trace_reg_n},   32'd0);
        chk({tag, " nt.trace_data"},  trace_data_n,           32'd0);
        chk({tag, " nt.trace_pc"},    trace_pc_n,             32'd0);
    endtask

    initial begin
        //             rw   m2r  ws     rdata         alu           pc            simm          instr  wreg ra1 ra2  e_wd          e_rd1         e_rd2         tv   treg e_tdata       e_tpc         cnt
        vecs[0] = '{1'b1,1'b0,2'b00,32'h0,        32'h12345678,32'h00001000,32'h0,        32'd1, 5'd5, 5'd5, 5'd0, 32'h12345678,32'h12345678,32'h0,        1'b1,5'd5, 32'h12345678,32'h00001000,32'd1};
        vecs[1] = '{1'b1,1'b0,2'b00,32'h0,        32'hDEADBEEF,32'h00001004,32'h0,        32'd2, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF,32'h0,        32'h12345678,1'b0,5'd5, 32'h12345678,32'h00001000,32'd2};
        vecs[2] = '{1'b1,1'b0,2'b01,32'h0,        32'h0,        32'h00003000,32'h0,        32'd3, 5'd31,5'd31,5'd5, 32'h00003008,32'h00003008,32'h12345678,1'b1,5'd31,32'h00003008,32'h00003000,32'd3};
        vecs[3] = '{1'b0,1'b0,2'b10,32'h0,        32'h0,        32'h00003004,32'hFFFF8001,32'd0, 5'd7, 5'd31,5'd7, 32'h80010000,32'h00003008,32'h0,        1'b0,5'd31,32'h00003008,32'h00003000,32'd3};
        vecs[4] = '{1'b1,1'b1,2'b00,32'hA5A5A5A5,32'h0,        32'h00004000,32'h0,        32'd4, 5'd7, 5'd7, 5'd7, 32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5,1'b1,5'd7, 32'hA5A5A5A5,32'h00004000,32'd4};
        vecs[5] = '{1'b1,1'b0,2'b11,32'h0,        32'h0,        32'h00004004,32'hFFFF8001,32'd5, 5'd5, 5'd5, 5'd7, 32'hFFFF8001,32'hFFFF8001,32'hA5A5A5A5,1'b1,5'd5, 32'hFFFF8001,32'h00004004,32'd5};
        vecs[6] = '{1'b0,1'b0,2'b01,32'h0,        32'h0,        32'hFFFFFFFC,32'h0,        32'd6, 5'd9, 5'd5, 5'd31,32'h00000004,32'hFFFF8001,32'h00003008,1'b0,5'd5, 32'hFFFF8001,32'h00004004,32'd6};
        vecs[7] = '{1'b0,1'b0,2'b00,32'h0,        32'h0,        32'h0,        32'h0,        32'd0, 5'd0, 5'd7, 5'd5, 32'h0,        32'hA5A5A5A5,32'hFFFF8001,1'b0,5'd5, 32'hFFFF8001,32'h00004004,32'd6};

        // Reset state
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31);
        #2;
        chk("reset RD1", RD1, 32'h0);
        chk("reset RD2", RD2, 32'h0);
        chk("reset retired_cnt", retired_cnt, 32'h0);
        chk("reset trace_valid", {31'd0, trace_valid}, 32'h0);
        chk("reset trace_data", trace_data, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].rw, vecs[i].m2r, vecs[i].ws, vecs[i].rdata, vecs[i].alu,
                  vecs[i].pc, vecs[i].simm, vecs[i].instr, vecs[i].wreg,
                  vecs[i].ra1, vecs[i].ra2);
            #1;
            chk($sformatf("v%0d WD_W", i), WD_W, vecs[i].e_wd);
            chk($sformatf("v%0d RD1", i),  RD1,  vecs[i].e_rd1);
            chk($sformatf("v%0d RD2", i),  RD2,  vecs[i].e_rd2);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d trace_valid", i), {31'd0, trace_valid}, {31'd0, vecs[i].e_tv});
            chk($sformatf("v%0d trace_reg", i),   {27'd0, trace_reg},   {27'd0, vecs[i].e_treg});
            chk($sformatf("v%0d trace_data", i),  trace_data,           vecs[i].e_tdata);
            chk($sformatf("v%0d trace_pc", i),    trace_pc,             vecs[i].e_tpc);
            chk($sformatf("v%0d retired_cnt", i), retired_cnt,          vecs[i].e_cnt);
            chk_nt_trace($sformatf("v%0d", i));
        end

        // Dual-port bypass of the same register, and tracing disabled
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h00000077, 32'h00005000, 32'h0, 32'd7, 5'd3, 5'd3, 5'd3);
        #1;
        chk("byp3 RD1", RD1, 32'h77);
        chk("byp3 RD2", RD2, 32'h77);
        chk("byp3 nt.RD1", RD1_n, 32'h77);
        @(posedge clk);
        #1;
        chk("byp3 trace_reg", {27'd0, trace_reg}, 32'd3);
        chk("byp3 trace_data", trace_data, 32'h77);
        chk_nt_trace("byp3");

        // Counter wrap and bubble
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
        dut.cnt_q = 32'hFFFFFFFF;
        #1;
        chk("wrap preload", retired_cnt, 32'hFFFFFFFF);
        Instr_W = 32'h00000001;
        @(posedge clk);
        #1;
        chk("wrap to zero", retired_cnt, 32'h0);
        chk("wrap RD1 $3 stored", RD1, 32'h77);
        @(negedge clk);
        Instr_W = 32'h0;
        @(posedge clk);
        #1;
        chk("bubble no count", retired_cnt, 32'h0);

        // Asynchronous reset mid-cycle
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h00000011, 32'h00006000, 32'h0, 32'd1, 5'd8, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h00000022, 32'h00006004, 32'h0, 32'd1, 5'd9, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd9);
        #1;
        chk("pre-reset RD1 $8", RD1, 32'h11);
        chk("pre-reset RD2 $9", RD2, 32'h22);
        chk("pre-reset retired_cnt", retired_cnt, 32'd2);
        #1;
        reset = 1'b0;
        #1;
        chk("async reset RD1", RD1, 32'h0);
        chk("async reset RD2", RD2, 32'h0);
        chk("async reset retired_cnt", retired_cnt, 32'h0);
        chk("async reset trace_valid", {31'd0, trace_valid}, 32'h0);
        chk("async reset trace_reg", {27'd0, trace_reg}, 32'h0);
        chk("async reset trace_pc", trace_pc, 32'h0);
        drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h000000AB, 32'h00007000, 32'h0, 32'd1, 5'd12, 5'd12, 5'd8);
        #1;
        chk("in-reset bypass WD", RD1, 32'h000000AB);
        @(posedge clk);
        #1;
        RegWrite_W = 1'b0;
        #1;
        chk("in-reset no write $12", RD1, 32'h0);
        chk("in-reset $8 zero", RD2, 32'h0);
        chk("in-reset no count", retired_cnt, 32'h0);
        chk("in-reset trace_valid", {31'd0, trace_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h00000099, 32'h00008000, 32'h0, 32'd1, 5'd10, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        chk("post-reset trace_valid", {31'd0, trace_valid}, 32'd1);
        chk("post-reset trace_reg", {27'd0, trace_reg}, 32'd10);
        chk("post-reset retired_cnt", retired_cnt, 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd9);
        #1;
        chk("post-reset $10 stored", RD1, 32'h99);
        chk("post-reset $9 cleared", RD2, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
